multdiv_unit: RTL and testbench

- Iterative signed 32-bit multiply/divide unit consumed by the processor's execute stage.
- Execute stage pulses a start strobe with bypassed operands and holds its early pipeline latches stalled until data_resultRDY.
- Result and exception feed the XM-latch input mux and the rStatus encoder (codes 4/5).
- Multiply: radix-4 modified Booth. Divide: restoring divide on magnitudes.

---
 rtl/multdiv_pkg.sv | 39 +++
 rtl/multdiv_unit_booth.sv | 27 ++
 rtl/multdiv_unit.sv | 178 +++++++++++++++++
 tb/tb_multdiv_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  // Control FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Step counts for the default 32-bit configuration.
  localparam int DEF_WIDTH  = 32;
  localparam int MULT_STEPS = DEF_WIDTH / 2;
  localparam int DIV_STEPS  = DEF_WIDTH;

  // Radix-4 Booth partial-product selections.
  typedef enum logic [2:0] {
    ZERO     = 3'd0,
    PLUS_M   = 3'd1,
    PLUS_2M  = 3'd2,
    MINUS_2M = 3'd3,
    MINUS_M  = 3'd4
  } booth_sel_t;

  // Map {b[i+1], b[i], b[i-1]} to the partial-product selection.
  function automatic booth_sel_t booth_decode(input logic [2:0] bits);
    booth_sel_t sel;
    case (bits)
      3'b001, 3'b010: sel = PLUS_M;
      3'b011:         sel = PLUS_2M;
      3'b100:         sel = MINUS_2M;
      3'b101, 3'b110: sel = MINUS_M;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multdiv_unit_booth.sv
// One radix-4 Booth step: picks 0, +-M or +-2M from the sign-extended multiplicand.
module booth_radix4_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         i_bits,
  input  logic [WIDTH+1:0]   i_mcand,
  output logic [WIDTH+1:0]   o_pp
);

  booth_sel_t w_sel;

  // Decode the three multiplier bits into a signed multiple of the multiplicand.
  always_comb begin
    w_sel = booth_decode(i_bits);
    o_pp  = '0;
    case (w_sel)
      PLUS_M:   o_pp = i_mcand;
      PLUS_2M:  o_pp = i_mcand << 1;
      MINUS_2M: o_pp = -(i_mcand << 1);
      MINUS_M:  o_pp = -i_mcand;
      default:  o_pp = '0;
    endcase
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-4 Booth) / divide (restoring on magnitudes).
//
// state | meaning
// IDLE  | waiting for a start strobe
// MULT  | Booth steps in flight, two multiplier bits per cycle
// DIV   | restoring divide steps in flight, one quotient bit per cycle
// DONE  | result valid, completion pulse high for this single cycle
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int MSTEPS = WIDTH / 2;
  localparam int DSTEPS = WIDTH;
  localparam int CW     = $clog2(DSTEPS);
  localparam logic [CW-1:0] M_LAST = CW'(MSTEPS - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DSTEPS - 1);

  state_t r_state;
  state_t w_state_next;
  logic [CW-1:0] r_count;

  logic w_start_mult;
  logic w_start_div;
  logic w_start;
  logic w_mult_last;
  logic w_div_last;

  // Multiply datapath: upper half carries two guard bits so +-2M never overflows.
  logic signed [WIDTH+1:0] r_mcand;
  logic signed [WIDTH+1:0] r_acc;
  logic [WIDTH-1:0]        r_mplr;
  logic                    r_prev;
  logic [WIDTH+1:0]        w_pp;
  logic signed [WIDTH+1:0] w_sum;
  logic signed [WIDTH+1:0] w_acc_next;
  logic [WIDTH-1:0]        w_mplr_next;
  logic                    w_mult_exc;

  // Divide datapath on magnitudes; |INT_MIN| fits as an unsigned WIDTH value.
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_neg;
  logic             r_dvz;
  logic             r_ovf;
  logic [WIDTH:0]   w_rem_shift;
  logic             w_keep;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_quo_signed;

  logic [WIDTH-1:0] r_result;
  logic             r_exc;

  // A new strobe always restarts; multiply wins when both arrive together.
  assign w_start_mult = ctrl_MULT;
  assign w_start_div  = ctrl_DIV & ~ctrl_MULT;
  assign w_start      = ctrl_MULT | ctrl_DIV;
  assign w_mult_last  = (r_state == MULT) && (r_count == M_LAST) && !w_start;
  assign w_div_last   = (r_state == DIV)  && (r_count == D_LAST) && !w_start;

  booth_radix4_step #(.WIDTH(WIDTH)) u_booth (
    .i_bits  ({r_mplr[1:0], r_prev}),
    .i_mcand (r_mcand),
    .o_pp    (w_pp)
  );

  // Booth accumulate followed by a 2-bit arithmetic shift of {acc, multiplier}.
  always_comb begin
    w_sum       = r_acc + $signed(w_pp);
    w_acc_next  = w_sum >>> 2;
    w_mplr_next = {w_sum[1:0], r_mplr[WIDTH-1:2]};
    w_mult_exc  = (w_acc_next[WIDTH-1:0] != {WIDTH{w_mplr_next[WIDTH-1]}});
  end

  // Restoring step: shift in the next dividend bit and keep the difference if it fits.
  always_comb begin
    w_rem_shift  = {r_rem, r_quo[WIDTH-1]};
    w_keep       = (w_rem_shift >= {1'b0, r_dvsr});
    w_rem_next   = w_keep ? (w_rem_shift[WIDTH-1:0] - r_dvsr) : w_rem_shift[WIDTH-1:0];
    w_quo_next   = {r_quo[WIDTH-2:0], w_keep};
    w_quo_signed = r_neg ? -w_quo_next : w_quo_next;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; strobes take effect from any state.
  always_comb begin
    w_state_next = r_state;
    if (w_start_mult) begin
      w_state_next = MULT;
    end else if (w_start_div) begin
      w_state_next = DIV;
    end else begin
      case (r_state)
        MULT:    if (r_count == M_LAST) w_state_next = DONE;
        DIV:     if (r_count == D_LAST) w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count  <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplr   <= '0;
      r_prev   <= 1'b0;
      r_dvsr   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_neg    <= 1'b0;
      r_dvz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else begin
      if (w_start_mult) begin
        r_count <= '0;
        r_mcand <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
        r_acc   <= '0;
        r_mplr  <= data_operandB;
        r_prev  <= 1'b0;
      end else if (w_start_div) begin
        r_count <= '0;
        r_quo   <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        r_dvsr  <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        r_rem   <= '0;
        r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_dvz   <= (data_operandB == '0);
        r_ovf   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
      end else if (r_state == MULT) begin
        r_count <= r_count + 1'b1;
        r_acc   <= w_acc_next;
        r_mplr  <= w_mplr_next;
        r_prev  <= r_mplr[1];
      end else if (r_state == DIV) begin
        r_count <= r_count + 1'b1;
        r_rem   <= w_rem_next;
        r_quo   <= w_quo_next;
      end

      if (w_mult_last) begin
        r_result <= w_mplr_next;
        r_exc    <= w_mult_exc;
      end else if (w_div_last) begin
        r_result <= r_dvz ? '0 : w_quo_signed;
        r_exc    <= r_dvz | r_ovf;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == DONE);
  assign busy           = (r_state == MULT) || (r_state == DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, results, exceptions, abort and reset.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic        exc;
    string       name;
  } vec_t;

  vec_t vq[$];

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic d, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res,
                              input logic exc, input string name);
    vec_t v;
    v.m = m; v.d = d; v.a = a; v.b = b;
    v.lat = m ? 17 : 33;
    v.res = res; v.exc = exc; v.name = name;
    return v;
  endfunction

  // Runs one operation from its start cycle; operands become garbage after cycle 0.
  // With has_next, the next strobe is driven in the DONE cycle (back-to-back).
  task automatic run_vec(input vec_t v, input bit chained, input bit has_next, input vec_t nxt);
    bit          timing_ok;
    logic [31:0] got_res;
    logic        got_exc;
    int          last;
    timing_ok = 1'b1;
    got_res   = '0;
    got_exc   = 1'b0;
    last      = has_next ? v.lat : v.lat + 1;
    if (!chained) begin
      @(negedge clock);
      ctrl_MULT = v.m; ctrl_DIV = v.d;
      data_operandA = v.a; data_operandB = v.b;
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge clock);
      if (data_resultRDY !== (k == v.lat)) timing_ok = 1'b0;
      if (busy !== (k < v.lat)) timing_ok = 1'b0;
      if (k == v.lat) begin
        got_res = data_result;
        got_exc = data_exception;
      end
      if (has_next && k == v.lat) begin
        ctrl_MULT = nxt.m; ctrl_DIV = nxt.d;
        data_operandA = nxt.a; data_operandB = nxt.b;
      end else begin
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom;
      end
    end
    check({v.name, " timing"}, 32'(timing_ok), 32'd1);
    check({v.name, " result"}, got_res, v.res);
    check({v.name, " exception"}, 32'(got_exc), 32'(v.exc));
  endtask

  initial begin : stimulus
    vec_t        none;
    bit          ok;
    logic [31:0] sres;
    none = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "none");

    vq.push_back(mk(1, 0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, "mul 7*-3"));
    vq.push_back(mk(1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1, "mul 2^16*2^16"));
    vq.push_back(mk(1, 0, 32'h80000000, 32'h00000001, 32'h80000000, 0, "mul min*1"));
    vq.push_back(mk(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, "mul -1*-1"));
    vq.push_back(mk(1, 0, 32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1, "mul max*2"));
    vq.push_back(mk(1, 0, 32'h80000000, 32'h80000000, 32'h00000000, 1, "mul min*min"));
    vq.push_back(mk(1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "mul min*-1"));
    vq.push_back(mk(1, 1, 32'h00000006, 32'h00000007, 32'h0000002A, 0, "both 6,7"));
    vq.push_back(mk(0, 1, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 0, "div -100/7"));
    vq.push_back(mk(0, 1, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 0, "div 100/-7"));
    vq.push_back(mk(0, 1, 32'h00000005, 32'h00000000, 32'h00000000, 1, "div 5/0"));
    vq.push_back(mk(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div min/-1"));
    vq.push_back(mk(0, 1, 32'h80000000, 32'h00000002, 32'hC0000000, 0, "div min/2"));
    vq.push_back(mk(0, 1, 32'h80000000, 32'h00000001, 32'h80000000, 0, "div min/1"));
    vq.push_back(mk(0, 1, 32'h00000007, 32'h00000007, 32'h00000001, 0, "div 7/7"));
    vq.push_back(mk(0, 1, 32'h00000003, 32'h00000005, 32'h00000000, 0, "div 3/5"));

    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset result", data_result, 32'h0);
    check("reset exception", 32'(data_exception), 32'h0);
    check("reset rdy", 32'(data_resultRDY), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vq[i]) run_vec(vq[i], 1'b0, 1'b0, none);

    // Divide restarts a multiply at cycle 5; completion counts from the restart.
    ok = 1'b1; sres = '0;
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    for (int k = 1; k <= 39; k++) begin
      @(negedge clock);
      if (data_resultRDY !== (k == 38)) ok = 1'b0;
      if (busy !== (k < 38)) ok = 1'b0;
      if (k == 38) sres = data_result;
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      if (k == 5) begin
        ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd2;
      end
    end
    check("abort timing", 32'(ok), 32'd1);
    check("abort result", sres, 32'd4);

    // Reset at cycle 10 of a divide, together with a multiply strobe.
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd1000; data_operandB = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
      if (k == 10) begin
        reset = 1'b1; ctrl_MULT = 1'b1;
      end
    end
    @(negedge clock);
    reset = 1'b0; ctrl_MULT = 1'b0;
    check("midreset result", data_result, 32'h0);
    check("midreset exception", 32'(data_exception), 32'h0);
    check("midreset rdy", 32'(data_resultRDY), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("midreset quiet", 32'(ok), 32'd1);

    // Back-to-back: each new strobe lands in the previous DONE cycle.
    run_vec(mk(1, 0, 32'd6, 32'd7, 32'd42, 0, "b2b mul 6*7"), 1'b0, 1'b1,
            mk(0, 1, 32'd100, 32'd7, 32'd14, 0, "b2b div 100/7"));
    run_vec(mk(0, 1, 32'd100, 32'd7, 32'd14, 0, "b2b div 100/7"), 1'b1, 1'b1,
            mk(1, 0, 32'hFFFFFFFB, 32'd9, 32'hFFFFFFD3, 0, "b2b mul -5*9"));
    run_vec(mk(1, 0, 32'hFFFFFFFB, 32'd9, 32'hFFFFFFD3, 0, "b2b mul -5*9"), 1'b1, 1'b0, none);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
